// File: rtl/regfile_op_sequencer_if.sv
// Command and register-file bus of the register-file op sequencer.
//   master : command source plus register-file read data (drives cmd_*, rf_rdata*)
//   slave  : the sequencer (drives cmd_ready, rf_* controls, done/result/carry/op_count)
interface regfile_op_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
);
  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [DATA_W-1:0] cmd_imm;
  // Register-file pins
  logic              rf_mode;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rf_raddr1;
  logic [ADDR_W-1:0] rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  // Status
  logic              done;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic [15:0]       op_count;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rf_rdata1, rf_rdata2,
    input  cmd_ready, rf_mode, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2,
           done, result, carry, op_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rf_rdata1, rf_rdata2,
    output cmd_ready, rf_mode, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2,
           done, result, carry, op_count
  );
endinterface

// File: rtl/regfile_op_sequencer.sv
// Register-file micro-op sequencer: accepts one command (ADD/SUB/AND/LOADI), reads two
// sources, computes, and writes the result back, one op every four cycles.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : regfile_op_sequencer_if.slave (command handshake, register-file pins, status)
// Optional build macro RF_SEQ_R0_ZERO_EN: register 0 reads as zero and writes to it are dropped.
module regfile_op_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input logic                   clk,
  input logic                   reset,
  regfile_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StExec  = 2'd2,
    StWrite = 2'd3
  } state_e;

  localparam logic [1:0] OpAdd   = 2'b00;
  localparam logic [1:0] OpSub   = 2'b01;
  localparam logic [1:0] OpAnd   = 2'b10;
  localparam logic [1:0] OpLoadi = 2'b11;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic              rf_mode_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [ADDR_W-1:0] rf_raddr1_q;
  logic [ADDR_W-1:0] rf_raddr2_q;
  logic              carry_pend_q;  // carry of the op sitting in WRITE
  logic              done_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic [15:0]       op_count_q;

  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W:0]   alu;     // {carry, result}
  logic              wr_en;

  // Operand selection; addresses are still held from READ so rdata is stable here.
  always_comb begin
    opa = bus.rf_rdata1;
    opb = bus.rf_rdata2;
`ifdef RF_SEQ_R0_ZERO_EN
    if (rf_raddr1_q == '0) opa = '0;
    if (rf_raddr2_q == '0) opb = '0;
`endif
  end

  always_comb begin
    alu = '0;
    case (op_q)
      OpAdd:   alu = {1'b0, opa} + {1'b0, opb};
      OpSub:   alu = {(opa >= opb), opa - opb};  // carry = no borrow
      OpAnd:   alu = {1'b0, opa & opb};
      OpLoadi: alu = {1'b0, imm_q};
      default: alu = '0;
    endcase
  end

  always_comb begin
    wr_en = 1'b1;
`ifdef RF_SEQ_R0_ZERO_EN
    wr_en = (rd_q != '0);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= OpAdd;
      rd_q         <= '0;
      imm_q        <= '0;
      rf_mode_q    <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      rf_raddr1_q  <= '0;
      rf_raddr2_q  <= '0;
      carry_pend_q <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      op_count_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            rd_q        <= bus.cmd_rd;
            imm_q       <= bus.cmd_imm;
            // Read addresses go out now so they are valid throughout READ.
            rf_raddr1_q <= bus.cmd_rs1;
            rf_raddr2_q <= bus.cmd_rs2;
            state_q     <= StRead;
          end
        end
        StRead: begin
          state_q <= StExec;
        end
        StExec: begin
          rf_mode_q    <= wr_en;
          rf_waddr_q   <= rd_q;
          rf_wdata_q   <= alu[DATA_W-1:0];
          carry_pend_q <= alu[DATA_W];
          state_q      <= StWrite;
        end
        StWrite: begin
          rf_mode_q  <= 1'b0;
          done_q     <= 1'b1;
          result_q   <= rf_wdata_q;
          carry_q    <= carry_pend_q;
          op_count_q <= op_count_q + 16'd1;
          state_q    <= StIdle;
        end
        default: begin
          rf_mode_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.rf_mode   = rf_mode_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.rf_raddr1 = rf_raddr1_q;
  assign bus.rf_raddr2 = rf_raddr2_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.op_count  = op_count_q;

endmodule
